id_ex_stage: RTL and testbench

ID/EX pipeline stage of the 5-stage core, directly downstream of the combinational decoder.
- Registers the decoder's control bundle, operands, immediate and register specifiers into the EX stage.
- Selects the destination register.
- Detects load-use hazards, asserting a stall to IF/ID and inserting a bubble into EX.
- Honours a flush from branch resolution.
- Keeps a saturating bubble counter for performance debug.

---
 rtl/core_pkg.sv | 32 +++
 rtl/id_ex_stage_if.sv | 62 ++++++
 rtl/id_ex_stage_hazard_detect.sv | 26 ++
 rtl/id_ex_stage.sv | 114 +++++++++++
 tb/tb_id_ex_stage.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, ALU-op encodings and the decoder control bundle.
// Imported by the ID/EX stage and by later forwarding/EX work.
package core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_XOR = 4'd5
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoder-side inputs, EX-side registered outputs,
// the stall back to IF/ID and the bubble counter.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic              id_reg_write;
  logic              id_alu_src;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_mem_to_reg;
  logic              id_branch;
  logic [3:0]        id_alu_op;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc4;
  logic              flush;

  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_alu_src;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_mem_to_reg;
  logic              ex_branch;
  logic [3:0]        ex_alu_op;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_dest;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_pc4;
  logic              stall;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_reg_write, id_alu_src, id_mem_read, id_mem_write,
           id_mem_to_reg, id_branch, id_alu_op, id_uses_rt, id_rs, id_rt, id_rd,
           id_rs_data, id_rt_data, id_imm, id_pc4, flush,
    input  ex_valid, ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_branch, ex_alu_op, ex_rs, ex_rt, ex_dest,
           ex_rs_data, ex_rt_data, ex_imm, ex_pc4, stall, bubble_cnt
  );

  modport slave (
    input  id_valid, id_reg_write, id_alu_src, id_mem_read, id_mem_write,
           id_mem_to_reg, id_branch, id_alu_op, id_uses_rt, id_rs, id_rt, id_rd,
           id_rs_data, id_rt_data, id_imm, id_pc4, flush,
    output ex_valid, ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_branch, ex_alu_op, ex_rs, ex_rt, ex_dest,
           ex_rs_data, ex_rt_data, ex_imm, ex_pc4, stall, bubble_cnt
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use compare between the load sitting in EX and the
// instruction in ID. Kept separate so forwarding logic can reuse it.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              i_ex_valid,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_dest,
  input  logic              i_id_valid,
  input  logic              i_id_uses_rt,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  output logic              o_load_use
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = (i_id_rs == i_ex_dest);
  assign w_rt_hit = i_id_uses_rt & (i_id_rt == i_ex_dest);

  // A load into $zero produces nothing to wait for.
  assign o_load_use = i_ex_valid & i_ex_mem_read & (i_ex_dest != '0) &
                      i_id_valid & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush-to-bubble and a
// saturating count of load-use bubbles.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  logic              r_valid;
  ctrl_t             r_ctrl;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_dest;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc4;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_load_use;
  logic              w_bubble;
  ctrl_t             w_id_ctrl;
  logic [REG_AW-1:0] w_id_dest;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl.mem_read),
    .i_ex_dest     (r_dest),
    .i_id_valid    (bus.id_valid),
    .i_id_uses_rt  (bus.id_uses_rt),
    .i_id_rs       (bus.id_rs),
    .i_id_rt       (bus.id_rt),
    .o_load_use    (w_load_use)
  );

  assign w_id_ctrl = '{
    reg_write:  bus.id_reg_write,
    alu_src:    bus.id_alu_src,
    mem_read:   bus.id_mem_read,
    mem_write:  bus.id_mem_write,
    mem_to_reg: bus.id_mem_to_reg,
    branch:     bus.id_branch,
    alu_op:     alu_op_e'(bus.id_alu_op)
  };

  // Immediate-form instructions write rt, R-type writes rd.
  assign w_id_dest = bus.id_alu_src ? bus.id_rt : bus.id_rd;
  assign w_bubble  = bus.flush | w_load_use;

  // Flush kills the ID instruction, so holding it would be wrong.
  assign bus.stall = rst_n & w_load_use & ~bus.flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_dest       <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_pc4        <= '0;
      r_bubble_cnt <= '0;
    end else if (w_bubble) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_dest    <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_pc4     <= '0;
      if (!bus.flush && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end else begin
      r_valid   <= bus.id_valid;
      r_ctrl    <= bus.id_valid ? w_id_ctrl : '0;
      r_rs      <= bus.id_rs;
      r_rt      <= bus.id_rt;
      r_dest    <= w_id_dest;
      r_rs_data <= bus.id_rs_data;
      r_rt_data <= bus.id_rt_data;
      r_imm     <= bus.id_imm;
      r_pc4     <= bus.id_pc4;
    end
  end

  assign bus.ex_valid      = r_valid;
  assign bus.ex_reg_write  = r_ctrl.reg_write;
  assign bus.ex_alu_src    = r_ctrl.alu_src;
  assign bus.ex_mem_read   = r_ctrl.mem_read;
  assign bus.ex_mem_write  = r_ctrl.mem_write;
  assign bus.ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign bus.ex_branch     = r_ctrl.branch;
  assign bus.ex_alu_op     = r_ctrl.alu_op;
  assign bus.ex_rs         = r_rs;
  assign bus.ex_rt         = r_rt;
  assign bus.ex_dest       = r_dest;
  assign bus.ex_rs_data    = r_rs_data;
  assign bus.ex_rt_data    = r_rt_data;
  assign bus.ex_imm        = r_imm;
  assign bus.ex_pc4        = r_pc4;
  assign bus.bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver pushes hand-computed expectations,
// a negedge monitor pops them and compares. A CNT_W=3 copy checks saturation.
module tb_id_ex_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) bus ();
  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(3))  bus_s ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(3)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s.slave));

  typedef struct {
    bit         v;
    bit         rw, as, mr, mw, mtr, br;
    logic [3:0] op;
    bit         ur;
    logic [4:0] rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm, pc4;
  } id_t;

  typedef struct {
    bit          stall;
    bit          valid;
    logic [9:0]  ctrl;
    logic [4:0]  dest, rs, rt;
    logic [127:0] data;
    logic [15:0] cnt;
    logic [2:0]  sat;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   pend_v = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (pend_v) begin
      chk("ex_valid", 128'(bus.ex_valid), 128'(pend.valid));
      chk("ex_ctrl", 128'({bus.ex_reg_write, bus.ex_alu_src, bus.ex_mem_read, bus.ex_mem_write,
                           bus.ex_mem_to_reg, bus.ex_branch, bus.ex_alu_op}), 128'(pend.ctrl));
      chk("ex_dest", 128'(bus.ex_dest), 128'(pend.dest));
      chk("ex_rs_rt", 128'({bus.ex_rs, bus.ex_rt}), 128'({pend.rs, pend.rt}));
      chk("ex_data", {bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm, bus.ex_pc4}, pend.data);
      chk("bubble_cnt", 128'(bus.bubble_cnt), 128'(pend.cnt));
      chk("bubble_cnt_sat", 128'(bus_s.bubble_cnt), 128'(pend.sat));
      pend_v = 1'b0;
    end
    if (q.size() > 0) begin
      pend = q.pop_front();
      chk("stall", 128'(bus.stall), 128'(pend.stall));
      chk("stall_sat", 128'(bus_s.stall), 128'(pend.stall));
      pend_v = 1'b1;
    end
  end

  function automatic id_t mk(input bit v, input bit rw, input bit as, input bit mr, input bit mw,
                             input bit mtr, input bit br, input logic [3:0] op, input bit ur,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_t d;
    d.v = v; d.rw = rw; d.as = as; d.mr = mr; d.mw = mw; d.mtr = mtr; d.br = br;
    d.op = op; d.ur = ur; d.rs = rs; d.rt = rt; d.rd = rd;
    d.rs_data = $urandom; d.rt_data = $urandom; d.imm = $urandom; d.pc4 = $urandom;
    return d;
  endfunction

  function automatic id_t i_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return mk(1, 1, 0, 0, 0, 0, 0, ALU_ADD, 1, rs, rt, rd);
  endfunction
  function automatic id_t i_sub(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return mk(1, 1, 0, 0, 0, 0, 0, ALU_SUB, 1, rs, rt, rd);
  endfunction
  function automatic id_t i_lw(input logic [4:0] rs, input logic [4:0] rt);
    return mk(1, 1, 1, 1, 0, 1, 0, ALU_ADD, 0, rs, rt, 5'd0);
  endfunction
  function automatic id_t i_sw(input logic [4:0] rs, input logic [4:0] rt);
    return mk(1, 0, 1, 0, 1, 0, 0, ALU_ADD, 1, rs, rt, 5'd0);
  endfunction
  function automatic id_t i_addi(input logic [4:0] rs, input logic [4:0] rt);
    return mk(1, 1, 1, 0, 0, 0, 0, ALU_ADD, 0, rs, rt, 5'd0);
  endfunction
  function automatic id_t i_beq(input logic [4:0] rs, input logic [4:0] rt);
    return mk(1, 0, 0, 0, 0, 0, 1, ALU_SUB, 1, rs, rt, 5'd0);
  endfunction
  function automatic id_t i_rand();
    logic [31:0] r;
    r = $urandom;
    return mk(r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[10:7], r[11],
              r[16:12], r[21:17], r[26:22]);
  endfunction

  // e_cap: 1 = ID captured into EX, 0 = bubble. Expected state is for after the next edge.
  task automatic step(input id_t d, input bit rst, input bit fl, input bit e_stall,
                      input bit e_cap, input logic [4:0] e_dest, input int e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst;
    bus.id_valid = d.v;        bus_s.id_valid = d.v;
    bus.id_reg_write = d.rw;   bus_s.id_reg_write = d.rw;
    bus.id_alu_src = d.as;     bus_s.id_alu_src = d.as;
    bus.id_mem_read = d.mr;    bus_s.id_mem_read = d.mr;
    bus.id_mem_write = d.mw;   bus_s.id_mem_write = d.mw;
    bus.id_mem_to_reg = d.mtr; bus_s.id_mem_to_reg = d.mtr;
    bus.id_branch = d.br;      bus_s.id_branch = d.br;
    bus.id_alu_op = d.op;      bus_s.id_alu_op = d.op;
    bus.id_uses_rt = d.ur;     bus_s.id_uses_rt = d.ur;
    bus.id_rs = d.rs;          bus_s.id_rs = d.rs;
    bus.id_rt = d.rt;          bus_s.id_rt = d.rt;
    bus.id_rd = d.rd;          bus_s.id_rd = d.rd;
    bus.id_rs_data = d.rs_data; bus_s.id_rs_data = d.rs_data;
    bus.id_rt_data = d.rt_data; bus_s.id_rt_data = d.rt_data;
    bus.id_imm = d.imm;        bus_s.id_imm = d.imm;
    bus.id_pc4 = d.pc4;        bus_s.id_pc4 = d.pc4;
    bus.flush = fl;            bus_s.flush = fl;
    e = '{default: '0};
    if (rst) begin
      e.stall = e_stall;
      e.valid = e_cap & d.v;
      e.ctrl  = e.valid ? {d.rw, d.as, d.mr, d.mw, d.mtr, d.br, d.op} : 10'd0;
      e.dest  = e_cap ? e_dest : 5'd0;
      e.rs    = e_cap ? d.rs : 5'd0;
      e.rt    = e_cap ? d.rt : 5'd0;
      e.data  = e_cap ? {d.rs_data, d.rt_data, d.imm, d.pc4} : 128'd0;
      e.cnt   = 16'(e_cnt);
      e.sat   = (e_cnt > 7) ? 3'd7 : 3'(e_cnt);
    end
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    id_t d, c;
    int  n;
    bus.flush = 1'b0; bus_s.flush = 1'b0;
    bus.id_valid = 1'b0; bus_s.id_valid = 1'b0;

    // Reset with random ID activity
    step(i_rand(), 0, $urandom_range(0, 1), 0, 0, 0, 0);
    step(i_rand(), 0, $urandom_range(0, 1), 0, 0, 0, 0);

    // Basic capture
    step(i_add(1, 2, 3), 1, 0, 0, 1, 3, 0);
    step(i_lw(1, 4), 1, 0, 0, 1, 4, 0);
    // Load-use on rs
    step(i_lw(1, 5), 1, 0, 0, 1, 5, 0);
    d = i_sub(5, 6, 7);
    step(d, 1, 0, 1, 0, 0, 1);
    step(d, 1, 0, 0, 1, 7, 1);
    // Load-use on rt via SW
    step(i_lw(0, 5), 1, 0, 0, 1, 5, 1);
    d = i_sw(8, 5);
    step(d, 1, 0, 1, 0, 0, 2);
    step(d, 1, 0, 0, 1, 5, 2);
    // ADDI does not read rt
    step(i_lw(0, 5), 1, 0, 0, 1, 5, 2);
    step(i_addi(7, 5), 1, 0, 0, 1, 5, 2);
    // Load into $zero
    step(i_lw(1, 0), 1, 0, 0, 1, 0, 2);
    step(i_add(0, 9, 10), 1, 0, 0, 1, 10, 2);
    // Flush beats load-use
    step(i_lw(2, 5), 1, 0, 0, 1, 5, 2);
    step(i_beq(5, 6), 1, 1, 0, 0, 0, 2);
    step(i_add(5, 1, 2), 1, 0, 0, 1, 2, 2);
    // id_valid=0 captured with control cleared
    d = i_lw(3, 5);
    d.v = 1'b0;
    step(d, 1, 0, 0, 1, 5, 2);
    step(i_sub(5, 1, 11), 1, 0, 0, 1, 11, 2);
    // Reset during a stall
    step(i_lw(1, 5), 1, 0, 0, 1, 5, 2);
    d = i_sub(5, 6, 7);
    step(d, 0, 0, 0, 0, 0, 0);
    step(d, 1, 0, 0, 1, 7, 0);
    // Nine load-use bubbles: 16-bit counter reaches 9, 3-bit one sticks at 7
    for (int i = 1; i <= 9; i++) begin
      step(i_lw(1, 5), 1, 0, 0, 1, 5, i - 1);
      c = i_sub(5, 6, 7);
      step(c, 1, 0, 1, 0, 0, i);
      step(c, 1, 0, 0, 1, 7, i);
    end
    step(i_add(1, 2, 3), 1, 0, 0, 1, 3, 9);

    n = 0;
    while ((q.size() > 0 || pend_v) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() > 0 || pend_v) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
